sisc_fetch: RTL and testbench

Instruction fetch stage for the SISC processor. Holds the program counter, issues one request at a time to instruction memory over a req/ack handshake, and latches the returned word into the `ir` register. The `ir` register directly feeds the SISC datapath/control core. The core consumes `ir` with a valid/ready handshake and returns branch redirects, and fetch halts on an HLT opcode.

---
 rtl/sisc_fetch.sv | 145 ++++++++++++++
 tb/tb_sisc_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch.sv
// rtl/sisc_fetch.sv - SISC instruction fetch stage: PC, req/ack fetch, IR with valid/ready hand-off
//
// Holds the program counter, issues one instruction-memory request at a
// time, latches the returned word into ir and presents it to the core
// with a valid/ready handshake. Branch redirects are taken on consume
// cycles; consuming an HLT opcode stops fetching until reset.
//
// Optional feature macro: SISC_FETCH_REL_BR_EN
//   defined   - br_addr is a two's-complement offset added to pc
//   undefined - br_addr is an absolute target
//
// Ports:
//   clk       - clock, rising edge
//   rst_f     - synchronous active-high reset
//   im_req    - instruction-memory request (registered)
//   im_addr   - request address (the pc)
//   im_ack    - memory acknowledge, im_data valid in the same cycle
//   im_data   - instruction word from memory
//   ir        - instruction register to the core
//   ir_valid  - ir holds an unconsumed instruction
//   ir_ready  - core accepts ir this cycle
//   br_taken  - redirect, sampled only on a consume cycle
//   br_addr   - branch target or offset
//   pc        - address of the next fetch
//   halted    - fetch stopped by HLT

module sisc_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [3:0]         HLT_OP   = 4'hF
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_data,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              im_req_q, im_req_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] br_target;

  // pc already points past the branch while it sits in ir, so a relative
  // offset is applied to the incremented value.
  always_comb begin
`ifdef SISC_FETCH_REL_BR_EN
    br_target = pc_q + br_addr;
`else
    br_target = br_addr;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    im_req_d   = im_req_q;
    halted_d   = halted_q;

    case (state_q)
      S_FETCH: begin
        // Reset leaves us in FETCH with im_req low, so an ack arriving
        // before the request is actually on the bus is ignored here.
        if (im_req_q && im_ack) begin
          ir_d       = im_data;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          im_req_d   = 1'b0;
          state_d    = S_HOLD;
        end else begin
          im_req_d   = 1'b1;
        end
      end

      S_HOLD: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          if (ir_q[31:28] == HLT_OP) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            if (br_taken) begin
              pc_d = br_target;
            end
            im_req_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end

      S_HALT: begin
      end

      default: begin
        state_d  = S_FETCH;
        im_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      im_req_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      im_req_q   <= im_req_d;
      halted_q   <= halted_d;
    end
  end

  assign im_req   = im_req_q;
  assign im_addr  = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// tb/tb_sisc_fetch.sv - self-checking bench for sisc_fetch

module tb_sisc_fetch;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_f;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ack;
  logic [31:0]       im_data;
  logic [31:0]       ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the spec says the visible outputs are.
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_valid;
  logic        m_req;
  logic        m_halted;

  sisc_fetch #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .HLT_OP(4'hF)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_data  (im_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .pc       (pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        bt;
    logic [15:0] ba;
    logic        e_req;
    logic [15:0] e_addr;
    logic [31:0] e_ir;
    logic        e_valid;
    logic [15:0] e_pc;
    logic        e_halted;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] target(input logic [15:0] cur_pc, input logic [15:0] ba);
`ifdef SISC_FETCH_REL_BR_EN
    return cur_pc + ba;
`else
    return ba;
`endif
  endfunction

  // Branch operand needed to land on pc value x from the model's pc.
  function automatic logic [15:0] ba_for(input logic [15:0] x);
`ifdef SISC_FETCH_REL_BR_EN
    return x - m_pc;
`else
    return x;
`endif
  endfunction

  task automatic model_step(input logic r, a, input logic [31:0] d,
                            input logic rdy, bt, input logic [15:0] ba);
    if (r) begin
      m_pc = 16'h0000; m_ir = '0; m_valid = 1'b0; m_req = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // terminal
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (m_ir[31:28] == 4'hF) begin
          m_halted = 1'b1;
        end else begin
          if (bt) m_pc = target(m_pc, ba);
          m_req = 1'b1;
        end
      end
    end else begin
      if (m_req && a) begin
        m_ir = d; m_valid = 1'b1; m_pc = m_pc + 16'd1; m_req = 1'b0;
      end else begin
        m_req = 1'b1;
      end
    end
  endtask

  task automatic chk_model();
    chk("model.im_req", 32'(im_req), 32'(m_req));
    if (m_req) chk("model.im_addr", 32'(im_addr), 32'(m_pc));
    chk("model.ir", ir, m_ir);
    chk("model.ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("model.pc", 32'(pc), 32'(m_pc));
    chk("model.halted", 32'(halted), 32'(m_halted));
  endtask

  // One clock: drive at the negedge, update model at the posedge, compare
  // at the following negedge.
  task automatic cycle(input logic r, a, input logic [31:0] d,
                       input logic rdy, bt, input logic [15:0] ba);
    rst_f = r; im_ack = a; im_data = d; ir_ready = rdy; br_taken = bt; br_addr = ba;
    @(posedge clk);
    model_step(r, a, d, rdy, bt, ba);
    @(negedge clk);
    chk_model();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [31:0] ir_hold;

    rst_f = 1'b1; im_ack = 1'b0; im_data = '0; ir_ready = 1'b0;
    br_taken = 1'b0; br_addr = '0;
    m_pc = 16'h0; m_ir = '0; m_valid = 1'b0; m_req = 1'b0; m_halted = 1'b0;
    @(negedge clk);

    // rst ack data rdy bt ba | req addr ir valid pc halted
    vecs[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0,        1'b0, 16'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 32'h0,        1'b0, 16'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h10000001, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h10000001, 1'b1, 16'h1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 16'h0, 1'b1, 16'h1, 32'h10000001, 1'b0, 16'h1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h20000002, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h20000002, 1'b1, 16'h2, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 16'h7, 1'b0, 16'h0, 32'h20000002, 1'b1, 16'h2, 1'b0};

    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].rst, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].bt, vecs[i].ba);
      chk($sformatf("vec%0d.im_req", i), 32'(im_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d.im_addr", i), 32'(im_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.ir", i), ir, vecs[i].e_ir);
      chk($sformatf("vec%0d.ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].e_halted));
    end

    // Memory wait of 3 cycles at address 5.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ba_for(16'h5));
    chk("wait.req0", 32'(im_req), 32'd1);
    chk("wait.addr0", 32'(im_addr), 32'h5);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("wait.req%0d", i + 1), 32'(im_req), 32'd1);
      chk($sformatf("wait.addr%0d", i + 1), 32'(im_addr), 32'h5);
      chk($sformatf("wait.valid%0d", i + 1), 32'(ir_valid), 32'd0);
    end
    cycle(1'b0, 1'b1, 32'h30000003, 1'b0, 1'b0, 16'h0);
    chk("wait.valid_after_ack", 32'(ir_valid), 32'd1);
    chk("wait.ir", ir, 32'h30000003);
    chk("wait.pc", 32'(pc), 32'h6);

    // Backpressure with noise on ack and br_taken.
    ir_hold = ir;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 32'hCAFE0000 + 32'(i), 1'b0, 1'b1, 16'h1234);
      chk($sformatf("bp.ir%0d", i), ir, ir_hold);
      chk($sformatf("bp.req%0d", i), 32'(im_req), 32'd0);
      chk($sformatf("bp.pc%0d", i), 32'(pc), 32'h6);
      chk($sformatf("bp.valid%0d", i), 32'(ir_valid), 32'd1);
    end

    // Branch consumed at pc 0x0011 with br_addr 0xFFFE.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ba_for(16'h10));
    cycle(1'b0, 1'b1, 32'h40000004, 1'b0, 1'b0, 16'h0);
    chk("br.pc_before", 32'(pc), 32'h11);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'hFFFE);
    chk("br.not_consumed_pc", 32'(pc), 32'h11);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'hFFFE);
    chk("br.req", 32'(im_req), 32'd1);
`ifdef SISC_FETCH_REL_BR_EN
    chk("br.im_addr", 32'(im_addr), 32'h000F);
`else
    chk("br.im_addr", 32'(im_addr), 32'hFFFE);
`endif

    // Wrap at 0xFFFF, then halt with a branch on the consume cycle.
    cycle(1'b0, 1'b1, 32'h50000005, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ba_for(16'hFFFF));
    chk("wrap.addr", 32'(im_addr), 32'hFFFF);
    cycle(1'b0, 1'b1, 32'hF0000000, 1'b0, 1'b0, 16'h0);
    chk("wrap.pc", 32'(pc), 32'h0000);
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 16'h1234);
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.req", 32'(im_req), 32'd0);
    chk("halt.valid", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 16'h0040);
      chk($sformatf("halt.req%0d", i), 32'(im_req), 32'd0);
      chk($sformatf("halt.pc%0d", i), 32'(pc), 32'h0000);
    end

    // Reset during FETCH with an ack in the same cycle.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    chk("rst.halted_clear", 32'(halted), 32'd0);
    idle();
    chk("rst.fetch_req", 32'(im_req), 32'd1);
    cycle(1'b1, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 16'h0);
    chk("rst.ir", ir, 32'h0);
    chk("rst.valid", 32'(ir_valid), 32'd0);
    chk("rst.pc", 32'(pc), 32'h0);
    chk("rst.req_low", 32'(im_req), 32'd0);
    idle();
    chk("rst.req_again", 32'(im_req), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, a, rdy, bt;
      logic [31:0] d;
      logic [15:0] ba;
      r   = ($urandom_range(0, 79) == 0);
      a   = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      bt  = ($urandom_range(0, 2) == 0);
      d   = $urandom;
      ba  = 16'($urandom);
      cycle(r, a, d, rdy, bt, ba);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
